// File: rtl/alu_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_ex_stage (with alu_core)
// Brief    : Execute stage: 32-bit ALU core feeding a 2-entry result FIFO,
//            with a saturating signed-overflow event counter.
// Revision : 1.0 - initial release
// ============================================================================

module alu_core (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  output logic [31:0] o_result,
  output logic        o_carry,
  output logic        o_ovf
);
  logic [31:0] w_bmux;
  logic [32:0] w_sum;
  logic        w_binv;

  // binv doubles as the adder carry-in, so ADD/SUB/SLT share one adder.
  assign w_binv  = i_op[2];
  assign w_bmux  = w_binv ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_bmux} + {32'd0, w_binv};
  assign o_carry = w_sum[32];

  always_comb begin
    o_result = '0;
    o_ovf    = 1'b0;
    case (i_op[1:0])
      2'b00: o_result = i_a & w_bmux;
      2'b01: o_result = i_a | w_bmux;
      2'b10: begin
        o_result = w_sum[31:0];
        if (w_binv)
          o_ovf = (i_a[31] != i_b[31]) && (w_sum[31] != i_a[31]);
        else
          o_ovf = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
      end
      default: o_result = {31'd0, w_sum[31]};
    endcase
  end
endmodule

module alu_ex_stage #(
  parameter int DEPTH     = 2,
  parameter int OVF_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  input  logic [2:0]           in_op,
  input  logic [4:0]           in_rd,
  input  logic                 in_wen,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic                 out_zero,
  output logic                 out_carry,
  output logic                 out_ovf,
  output logic [4:0]           out_rd,
  output logic                 out_wen,
  output logic [OVF_CNT_W-1:0] ovf_count
);
  localparam int                 c_ENT_W   = 41;
  localparam logic [1:0]         c_FULL    = DEPTH[1:0];
  localparam logic [OVF_CNT_W-1:0] c_OVF_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};

  logic [c_ENT_W-1:0]   r_mem [2];
  logic                 r_wptr;
  logic                 r_rptr;
  logic [1:0]           r_count;
  logic [OVF_CNT_W-1:0] r_ovf_cnt;

  logic [31:0]          w_result;
  logic                 w_carry;
  logic                 w_ovf;
  logic                 w_accept;
  logic                 w_pop;
  logic [c_ENT_W-1:0]   w_entry;
  logic [c_ENT_W-1:0]   w_head;

  alu_core u_core (
    .i_a      (in_a),
    .i_b      (in_b),
    .i_op     (in_op),
    .o_result (w_result),
    .o_carry  (w_carry),
    .o_ovf    (w_ovf)
  );

  // Ready depends only on registered occupancy; a same-cycle pop on a full
  // FIFO frees its slot for the next cycle, keeping out_ready off this path.
  assign in_ready  = (r_count != c_FULL);
  assign out_valid = (r_count != 2'd0);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_entry = {w_result, (w_result == 32'd0), w_carry, w_ovf, in_rd, in_wen};
  assign w_head  = r_mem[r_rptr];

  assign out_result = w_head[40:9];
  assign out_zero   = w_head[8];
  assign out_carry  = w_head[7];
  assign out_ovf    = w_head[6];
  assign out_rd     = w_head[5:1];
  assign out_wen    = w_head[0];
  assign ovf_count  = r_ovf_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0]  <= '0;
      r_mem[1]  <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wptr] <= w_entry;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop)
        r_rptr <= ~r_rptr;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_accept && w_ovf && (r_ovf_cnt != '1))
        r_ovf_cnt <= r_ovf_cnt + c_OVF_ONE;
    end
  end
endmodule

`default_nettype wire
